// File: rtl/cc_mux21_arbiter.sv
// Two-requester arbiter driving a shared 2:1 data mux, with burst-limited fairness.
// Grants decode from state; z/valid are registered one cycle after the grant; the only backpressure is grant withholding.
module cc_mux21_arbiter #(
  parameter int MUX21ARB_DATAWIDTH = 8,
  parameter int MUX21ARB_BURSTMAX  = 4
) (
  input  logic                          CC_MUX21ARB_CLOCK_50,
  input  logic                          CC_MUX21ARB_RESET_InHigh,
  input  logic                          CC_MUX21ARB_req1_In,
  input  logic                          CC_MUX21ARB_req2_In,
  input  logic [MUX21ARB_DATAWIDTH-1:0] CC_MUX21ARB_data1_InBUS,
  input  logic [MUX21ARB_DATAWIDTH-1:0] CC_MUX21ARB_data2_InBUS,
  output logic                          CC_MUX21ARB_grant1_Out,
  output logic                          CC_MUX21ARB_grant2_Out,
  output logic                          CC_MUX21ARB_select_Out,
  output logic [MUX21ARB_DATAWIDTH-1:0] CC_MUX21ARB_z_Out,
  output logic                          CC_MUX21ARB_valid_Out
);

  localparam int CNT_W = $clog2(MUX21ARB_BURSTMAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUX21ARB_BURSTMAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            last_q, last_d;   // 0: requester 1 served last, 1: requester 2
  logic [MUX21ARB_DATAWIDTH-1:0]   z_q, z_d;
  logic                            valid_q, valid_d;

  logic req1, req2;
  assign req1 = CC_MUX21ARB_req1_In;
  assign req2 = CC_MUX21ARB_req2_In;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    z_d     = z_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req1 && req2) state_d = last_q ? OWN1 : OWN2;
        else if (req1)    state_d = OWN1;
        else if (req2)    state_d = OWN2;
      end
      OWN1: begin
        last_d  = 1'b0;
        z_d     = CC_MUX21ARB_data1_InBUS;
        valid_d = 1'b1;
        if (!req1) begin
          cnt_d   = '0;
          state_d = req2 ? OWN2 : IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Burst exhausted: hand over if the other side waits, otherwise start a fresh burst.
          cnt_d = '0;
          if (req2) state_d = OWN2;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OWN2: begin
        last_d  = 1'b1;
        z_d     = CC_MUX21ARB_data2_InBUS;
        valid_d = 1'b1;
        if (!req2) begin
          cnt_d   = '0;
          state_d = req1 ? OWN1 : IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (req1) state_d = OWN1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CC_MUX21ARB_CLOCK_50) begin
    if (CC_MUX21ARB_RESET_InHigh) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      z_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      z_q     <= z_d;
      valid_q <= valid_d;
    end
  end

  assign CC_MUX21ARB_grant1_Out = (state_q == OWN1);
  assign CC_MUX21ARB_grant2_Out = (state_q == OWN2);
  assign CC_MUX21ARB_select_Out = (state_q == OWN2);
  assign CC_MUX21ARB_z_Out      = z_q;
  assign CC_MUX21ARB_valid_Out  = valid_q;

endmodule

// File: tb/tb_cc_mux21_arbiter.sv
// Directed bench for cc_mux21_arbiter (BURSTMAX=4, 8-bit data) with immediate-assertion checks.
module tb_cc_mux21_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req1, req2;
  logic [7:0] data1, data2;
  logic       grant1, grant2, sel, valid;
  logic [7:0] z;

  int n_assert = 0;
  int n_fail   = 0;

  cc_mux21_arbiter #(
    .MUX21ARB_DATAWIDTH(8),
    .MUX21ARB_BURSTMAX (4)
  ) dut (
    .CC_MUX21ARB_CLOCK_50    (clk),
    .CC_MUX21ARB_RESET_InHigh(rst),
    .CC_MUX21ARB_req1_In     (req1),
    .CC_MUX21ARB_req2_In     (req2),
    .CC_MUX21ARB_data1_InBUS (data1),
    .CC_MUX21ARB_data2_InBUS (data2),
    .CC_MUX21ARB_grant1_Out  (grant1),
    .CC_MUX21ARB_grant2_Out  (grant2),
    .CC_MUX21ARB_select_Out  (sel),
    .CC_MUX21ARB_z_Out       (z),
    .CC_MUX21ARB_valid_Out   (valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic g1, input logic g2,
                            input logic v, input logic [7:0] zz);
    check({tag, ".grant1"}, {31'd0, grant1}, {31'd0, g1});
    check({tag, ".grant2"}, {31'd0, grant2}, {31'd0, g2});
    check({tag, ".select"}, {31'd0, sel},    {31'd0, g2});
    check({tag, ".valid"},  {31'd0, valid},  {31'd0, v});
    check({tag, ".z"},      {24'd0, z},      {24'd0, zz});
  endtask

  initial begin
    logic exp_g1, prev_g1;

    // Reset with both requests held
    rst = 1'b1; req1 = 1'b1; req2 = 1'b1; data1 = 8'hA1; data2 = 8'hB2;
    step();
    step();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;

    // Both held: requester 1 first, then runs of four alternating grants
    prev_g1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      exp_g1 = ((i / 4) % 2) == 0;
      if (i == 0) check_outs("first_grant", 1'b1, 1'b0, 1'b0, 8'h00);
      else        check_outs($sformatf("burst%0d", i), exp_g1, !exp_g1, 1'b1,
                             prev_g1 ? 8'hA1 : 8'hB2);
      prev_g1 = exp_g1;
    end

    // In OWN1 at burst count 1: drop req1, requester 2 takes over with no bubble
    req1 = 1'b0;
    step();
    check_outs("handover", 1'b0, 1'b1, 1'b1, 8'hA1);
    step();
    check_outs("own2_first", 1'b0, 1'b1, 1'b1, 8'hB2);

    // Only req2 for 10 cycles, data2 = index; ownership persists across counter wraps
    for (int k = 0; k < 10; k++) begin
      data2 = 8'(k);
      step();
      check_outs($sformatf("solo2_%0d", k), 1'b0, 1'b1, 1'b1, 8'(k));
    end

    // Both drop: last granted word lands, then idle holds z while buses toggle
    req2 = 1'b0;
    step();
    check_outs("drop_last_word", 1'b0, 1'b0, 1'b1, 8'h09);
    data1 = 8'hFF; data2 = 8'hEE;
    step();
    check_outs("idle_hold1", 1'b0, 1'b0, 1'b0, 8'h09);
    data1 = 8'h55; data2 = 8'h66;
    step();
    check_outs("idle_hold2", 1'b0, 1'b0, 1'b0, 8'h09);

    // Requester 1 burst, reset at count 2, then a tie must go to requester 1
    req1 = 1'b1; data1 = 8'h11;
    step();
    check_outs("b1_c0", 1'b1, 1'b0, 1'b0, 8'h09);
    step();
    check_outs("b1_c1", 1'b1, 1'b0, 1'b1, 8'h11);
    step();
    check_outs("b1_c2", 1'b1, 1'b0, 1'b1, 8'h11);
    rst = 1'b1; req2 = 1'b1;
    step();
    check_outs("mid_reset", 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    step();
    check_outs("post_reset_tie", 1'b1, 1'b0, 1'b0, 8'h00);
    step();
    check_outs("post_reset_data", 1'b1, 1'b0, 1'b1, 8'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
